pipelined_addsub: RTL and testbench
===================================

// Module: pipelined_addsub
// PURPOSE
//  Parametrised, pipelined add/subtract unit; next generation of the 4-bit ripple adder.
//  WIDTH-bit operands are split into CHUNK-bit ripple segments, one segment per stage.
//  The carry is registered between stages so WIDTH scales without a long carry path.
//  A valid/ready stream handshake sits on both sides; it feeds the datapath/display logic.
// PARAMETERS
//  WIDTH   16  operand/result width in bits; must be a multiple of CHUNK
//  CHUNK    4  bits added per pipeline stage; STAGES = WIDTH/CHUNK (localparam, >=1)
// PORTS
//  clock      in   1      single clock, all state on rising edge
//  reset      in   1      synchronous, active-high
//  in_valid   in   1      operand beat offered
//  in_ready   out  1      unit can accept a beat this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  c_in       in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: a+b+c_in   1: a-b-c_in
//  out_valid  out  1      result beat present
//  out_ready  in   1      downstream accepts result this cycle
//  s          out  WIDTH  result
//  c_out      out  1      raw carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Transfer on a side occurs when valid && ready are both high on a rising clock edge.
//  - Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational).
//  - All stage registers load only when advance=1; bubbles are not compressed.
//  - Latency: accepted beat appears on out_valid exactly STAGES advancing cycles later.
//  - Throughput: one beat per cycle when out_ready is held high.
//  - Sub mode: b_eff = ~b, cin_eff = ~c_in, so the result is a + ~b + ~c_in.
//  - Stage k (0..STAGES-1): sum chunk k of a and b_eff with the carry registered by stage k-1.
//    Stage 0 uses cin_eff instead of a stage carry.
//  - Chunks k+1.. of a and b_eff are skew-registered, aligned with their stage.
//  - Result chunks 0..k-1 are deskew-registered so all of s is valid at the last stage.
//  - c_out = carry out of the top chunk.
//  - ovf = (a_msb == b_eff_msb) && (s_msb != a_msb), from the unsaturated sum.
//  - Outputs s, c_out and ovf are registered; they are held stable while out_valid && !out_ready.
//  - Reset: all stage valid bits, out_valid, s, c_out and ovf are 0 on the cycle after reset.
//    in_ready = 1 after reset.
//  - Reset mid-operation: all in-flight beats are discarded; no partial result is ever emitted.
//  - in_valid while in_ready=0: the beat is not taken; the source must hold it.
//  - Simultaneous in/out transfers in one cycle are legal, and occupancy stays constant.
//  - STAGES=1 (CHUNK=WIDTH) degenerates to a 1-cycle registered adder with the same handshake.
// CONFIGURATION
//  ADDSUB_SAT_EN defined: on ovf, s clamps to signed max or min.
//    Max is 0111..1 when a_msb=0; min is 1000..0 when a_msb=1.
//    c_out and ovf are unchanged by the clamp.
//  ADDSUB_SAT_EN undefined: s wraps modulo 2^WIDTH; no clamp logic is built.
// TESTING (WIDTH=16, CHUNK=4, latency 4, out_ready=1 unless stated)
//  1. a=0x1234 b=0x0FF1 c_in=0 sub=0 -> 4 cycles later s=0x2225 c_out=0 ovf=0.
//  2. a=0xFFFF b=0x0001 c_in=0 -> s=0x0000 c_out=1 ovf=0 (carry crosses all 4 stages).
//  3. a=0x0005 b=0x0007 sub=1 c_in=0 -> s=0xFFFE c_out=0 ovf=0.
//     Also a=0x0007 b=0x0005 sub=1 c_in=1 -> s=0x0001 c_out=1.
//  4. a=0x7FFF b=0x0001 add -> ovf=1, s=0x8000; with ADDSUB_SAT_EN s=0x7FFF.
//     Also a=0x8000 b=0x0001 sub -> ovf=1, s=0x7FFF; with ADDSUB_SAT_EN s=0x8000.
//  5. 8 back-to-back random beats with out_ready toggling 1,0,0,1,... ->
//     results match a scoreboard in order, none lost or duplicated, outputs stable while stalled.
//  6. reset for 1 cycle with 3 beats in flight ->
//     out_valid=0 for the next 4 cycles, then a fresh beat completes with latency 4.

Source files
------------

// File: rtl/pipelined_addsub_if.sv
// Operand/result stream bundle for pipelined_addsub.
// Handshake: a beat moves on a side at a rising edge where valid && ready are both high; valid
// must not depend on ready, and an offered beat with its data is held until it is taken.
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             c_out;
  logic             ovf;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, s, c_out, ovf
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, s, c_out, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: one CHUNK-bit ripple segment per stage, carry registered between stages.
// Optional ADDSUB_SAT_EN clamps the result to signed max/min on overflow.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                clock,
  input logic                reset,
  pipelined_addsub_if.slave  bus
);
  localparam int STAGES = WIDTH / CHUNK;

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  // Whole pipe moves together; a full output register that is not taken freezes every stage.
  assign advance      = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = advance;
  assign b_eff        = bus.sub ? ~bus.b : bus.b;
  assign cin_eff      = bus.sub ? ~bus.c_in : bus.c_in;

  for (genvar k = 0; k < STAGES; k = k + 1) begin : g_stage
    logic [CHUNK-1:0]       a_c;
    logic [CHUNK-1:0]       b_c;
    logic                   ci;
    logic                   vi;
    logic [CHUNK:0]         sum;
    logic [(k+1)*CHUNK-1:0] s_nxt;
    logic [(k+1)*CHUNK-1:0] s_ld;
    logic [(k+1)*CHUNK-1:0] s_q;
    logic                   vld_q;
    logic                   carry_q;

    if (k == 0) begin : g_in
      assign a_c   = bus.a[CHUNK-1:0];
      assign b_c   = b_eff[CHUNK-1:0];
      assign ci    = cin_eff;
      assign vi    = bus.in_valid;
      assign s_nxt = sum[CHUNK-1:0];
    end else begin : g_in
      assign a_c   = g_stage[k-1].g_skew.a_q[CHUNK-1:0];
      assign b_c   = g_stage[k-1].g_skew.b_q[CHUNK-1:0];
      assign ci    = g_stage[k-1].carry_q;
      assign vi    = g_stage[k-1].vld_q;
      assign s_nxt = {sum[CHUNK-1:0], g_stage[k-1].s_q};
    end

    assign sum = {1'b0, a_c} + {1'b0, b_c} + {{CHUNK{1'b0}}, ci};

    always_ff @(posedge clock) begin
      if (reset) begin
        vld_q   <= 1'b0;
        carry_q <= 1'b0;
        s_q     <= '0;
      end else if (advance) begin
        vld_q   <= vi;
        carry_q <= sum[CHUNK];
        s_q     <= s_ld;
      end
    end

    if (k < STAGES - 1) begin : g_skew
      // Operand chunks not yet summed ride along, shrinking by one chunk per stage.
      logic [WIDTH-(k+1)*CHUNK-1:0] a_q;
      logic [WIDTH-(k+1)*CHUNK-1:0] b_q;
      logic [WIDTH-(k+1)*CHUNK-1:0] a_src;
      logic [WIDTH-(k+1)*CHUNK-1:0] b_src;

      if (k == 0) begin : g_src
        assign a_src = bus.a[WIDTH-1:CHUNK];
        assign b_src = b_eff[WIDTH-1:CHUNK];
      end else begin : g_src
        assign a_src = g_stage[k-1].g_skew.a_q[WIDTH-k*CHUNK-1:CHUNK];
        assign b_src = g_stage[k-1].g_skew.b_q[WIDTH-k*CHUNK-1:CHUNK];
      end

      assign s_ld = s_nxt;

      always_ff @(posedge clock) begin
        if (advance) begin
          a_q <= a_src;
          b_q <= b_src;
        end
      end
    end else begin : g_last
      logic ovf_nxt;
      logic ovf_q;

      assign ovf_nxt = (a_c[CHUNK-1] == b_c[CHUNK-1]) && (sum[CHUNK-1] != a_c[CHUNK-1]);

`ifdef ADDSUB_SAT_EN
      assign s_ld = !ovf_nxt ? s_nxt :
                    a_c[CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign s_ld = s_nxt;
`endif

      always_ff @(posedge clock) begin
        if (reset) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= ovf_nxt;
        end
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].vld_q;
  assign bus.s         = g_stage[STAGES-1].s_q;
  assign bus.c_out     = g_stage[STAGES-1].carry_q;
  assign bus.ovf       = g_stage[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub (WIDTH=16, CHUNK=4): directed vector table, stall/reset sequences,
// and randomized traffic checked against an arithmetic reference model.
module tb_pipelined_addsub;
  localparam int W   = 16;
  localparam int LAT = 4;

  logic clock;
  logic reset;
  int   errors;
  int   checks;
  int   n_out;
  int   rdy_mode;
  int   rdy_cyc;

  pipelined_addsub_if #(.WIDTH(W)) bus ();

  pipelined_addsub #(.WIDTH(W), .CHUNK(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic [W+1:0] exp_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c_in;
    logic         sub;
    logic [W-1:0] s;
    logic         c_out;
    logic         ovf;
  } vec_t;

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // ---------------- reference model ----------------
  // Returns {s, c_out, ovf} from exact integer arithmetic.
  function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic c_in, logic sub);
    int sa, sb, ua, ub, ci, ex, ux;
    logic [W-1:0] s;
    logic c, o;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    ci = c_in;
    if (!sub) begin
      ex = sa + sb + ci;
      ux = ua + ub + ci;
      c  = (ux > 65535);
    end else begin
      ex = sa - sb - ci;
      c  = (ua >= ub + ci);
    end
    s = ex[W-1:0];
    o = (ex > 32767) || (ex < -32768);
`ifdef ADDSUB_SAT_EN
    if (o) s = (ex > 0) ? 16'h7FFF : 16'h8000;
`endif
    return {s, c, o};
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- out_ready driver ----------------
  initial begin
    logic [3:0] pat;
    pat = 4'b1001;
    bus.out_ready = 1'b1;
    rdy_cyc = 0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = pat[3 - (rdy_cyc % 4)];
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      rdy_cyc++;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic         prev_stall;
  logic [W-1:0] prev_s;
  logic         prev_c, prev_o;

  initial begin
    logic [W+1:0] e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clock);
      if (reset) begin
        exp_q.delete();
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", 32'(bus.out_valid), 32'd1);
          check("stall_hold", {bus.s, bus.c_out, bus.ovf}, {prev_s, prev_c, prev_o});
        end
        if (bus.out_valid && bus.out_ready) begin
          n_out++;
          if (exp_q.size() == 0) begin
            check("sb_unexpected_out", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("sb_result", {bus.s, bus.c_out, bus.ovf}, 32'(e));
          end
        end
        if (bus.in_valid && bus.in_ready)
          exp_q.push_back(model(bus.a, bus.b, bus.c_in, bus.sub));
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_s = bus.s;
        prev_c = bus.c_out;
        prev_o = bus.ovf;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the edge that took the beat.
  task automatic send_beat(logic [W-1:0] a, logic [W-1:0] b, logic c_in, logic sub);
    logic taken;
    taken = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.c_in = c_in;
    bus.sub = sub;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 200 && !taken; n++) begin
      @(negedge clock);
      taken = bus.in_ready;
      @(posedge clock);
      #1;
    end
    if (!taken) check("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 500) begin
      @(posedge clock);
      #1;
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  vec_t vecs[9];

  initial begin
    int lat, base;
    logic [W+1:0] e;
    logic [W-1:0] ra, rb;
    errors = 0;
    checks = 0;
    n_out = 0;
    rdy_mode = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.c_in = 1'b0;
    bus.sub = 1'b0;

`ifdef ADDSUB_SAT_EN
    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
`else
    vecs[0] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[1] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[2] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
`endif
    vecs[3] = '{16'h1234, 16'h0FF1, 1'b0, 1'b0, 16'h2225, 1'b0, 1'b0};
    vecs[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[6] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};
    vecs[8] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};

    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_s", 32'(bus.s), 32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed vectors, one at a time through an empty pipe.
    foreach (vecs[i]) begin
      send_beat(vecs[i].a, vecs[i].b, vecs[i].c_in, vecs[i].sub);
      wait_result(lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d_s", i), 32'(bus.s), 32'(vecs[i].s));
      check($sformatf("vec%0d_c_out", i), 32'(bus.c_out), 32'(vecs[i].c_out));
      check($sformatf("vec%0d_ovf", i), 32'(bus.ovf), 32'(vecs[i].ovf));
      @(posedge clock);
      #1;
    end

    // 8 back-to-back beats with out_ready toggling 1,0,0,1.
    base = n_out;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send_beat(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    drain();
    rdy_mode = 0;
    check("b2b_count", 32'(n_out - base), 32'd8);

    // Reset with three beats in flight.
    @(posedge clock);
    #1;
    for (int i = 0; i < 3; i++) send_beat(16'h1111 * 16'(i + 1), 16'h0101, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    base = n_out;
    for (int i = 0; i < LAT; i++) begin
      check($sformatf("flush_cyc%0d_out_valid", i), 32'(bus.out_valid), 32'd0);
      @(posedge clock);
      #1;
    end
    check("flush_no_output", 32'(n_out - base), 32'd0);
    send_beat(16'h4321, 16'h1234, 1'b1, 1'b0);
    wait_result(lat);
    check("post_reset_latency", 32'(lat), 32'(LAT));
    e = model(16'h4321, 16'h1234, 1'b1, 1'b0);
    check("post_reset_result", {bus.s, bus.c_out, bus.ovf}, 32'(e));
    @(posedge clock);
    #1;

    // Randomized traffic with random gaps and random back-pressure.
    base = n_out;
    rdy_mode = 2;
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 3))
        0:       ra = 16'h7FFF;
        1:       ra = 16'h8000;
        default: ra = 16'($urandom);
      endcase
      rb = ($urandom_range(0, 4) == 0) ? 16'hFFFF : 16'($urandom);
      send_beat(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    drain();
    rdy_mode = 0;
    check("random_count", 32'(n_out - base), 32'd150);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
